// File: rtl/encoder.sv
// Streams ASCII characters into SRAM as columns of a three-row, 4-bit-per-pixel image:
// rows hold the high nibble, the low nibble and their XOR at k, k+W and k+2W.
module encoder #(
    parameter int SRAM_DATA_WIDTH = 4,
    parameter int SRAM_ADDR_WIDTH = 7,
    parameter int DATA_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      width,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic                       SRAM_wen,
    output logic [SRAM_ADDR_WIDTH-1:0] SRAM_addr,
    output logic [SRAM_DATA_WIDTH-1:0] SRAM_wdata,
    output logic                       done
);

    typedef enum logic [2:0] {IDLE, FETCH, W0, W1, W2, DONE} state_t;

    localparam logic [DATA_WIDTH-1:0] PAD_CHAR = DATA_WIDTH'(8'h20);

    state_t                       state_q, state_d;
    logic [DATA_WIDTH-1:0]        w_q, w_d;
    logic [DATA_WIDTH-1:0]        col_q, col_d;
    logic [DATA_WIDTH-1:0]        char_q, char_d;
    logic                         pad_q, pad_d;
    logic                         wen_q, wen_d;
    logic                         done_q, done_d;
    logic [SRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [DATA_WIDTH-1:0]        next_char;
    logic [DATA_WIDTH-1:0]        col_plus_w;
    logic [DATA_WIDTH-1:0]        col_plus_2w;
    logic [DATA_WIDTH-1:0]        col_inc;

    function automatic logic [SRAM_DATA_WIDTH-1:0] hi_nib(input logic [DATA_WIDTH-1:0] c);
        return c[2*SRAM_DATA_WIDTH-1:SRAM_DATA_WIDTH];
    endfunction

    function automatic logic [SRAM_DATA_WIDTH-1:0] lo_nib(input logic [DATA_WIDTH-1:0] c);
        return c[SRAM_DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d = state_q;
        w_d     = w_q;
        col_d   = col_q;
        char_d  = char_q;
        pad_d   = pad_q;
        wen_d   = 1'b0;
        done_d  = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        next_char   = pad_q ? PAD_CHAR : in_data;
        // Sums are formed at full width and only then cut down to the SRAM address.
        col_plus_w  = col_q + w_q;
        col_plus_2w = col_plus_w + w_q;
        col_inc     = col_q + DATA_WIDTH'(1);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    w_d   = width;
                    col_d = '0;
                    pad_d = 1'b0;
                    if (width == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                // Once the message has ended, columns are filled with spaces without a handshake.
                if (pad_q || in_valid) begin
                    char_d  = next_char;
                    if (!pad_q) pad_d = in_last;
                    wen_d   = 1'b1;
                    addr_d  = SRAM_ADDR_WIDTH'(col_q);
                    wdata_d = hi_nib(next_char);
                    state_d = W0;
                end
            end
            W0: begin
                wen_d   = 1'b1;
                addr_d  = SRAM_ADDR_WIDTH'(col_plus_w);
                wdata_d = lo_nib(char_q);
                state_d = W1;
            end
            W1: begin
                wen_d   = 1'b1;
                addr_d  = SRAM_ADDR_WIDTH'(col_plus_2w);
                wdata_d = hi_nib(char_q) ^ lo_nib(char_q);
                state_d = W2;
            end
            W2: begin
                col_d = col_inc;
                if (col_inc == w_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            col_q   <= '0;
            char_q  <= '0;
            pad_q   <= 1'b0;
            wen_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            w_q     <= w_d;
            col_q   <= col_d;
            char_q  <= char_d;
            pad_q   <= pad_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = (state_q == FETCH) && !pad_q;
    assign SRAM_wen   = wen_q;
    assign SRAM_addr  = addr_q;
    assign SRAM_wdata = wdata_q;
    assign done       = done_q;

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for encoder: an SRAM image model filled from observed writes is
// compared against the image computed directly from the character stream.
module tb_encoder;

    logic       clk, rst_n;
    logic [7:0] width;
    logic       enable, in_valid, in_last;
    logic [7:0] in_data;
    logic       in_ready, SRAM_wen, done;
    logic [6:0] SRAM_addr;
    logic [3:0] SRAM_wdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [3:0] mem [128];
    int         wr_count, done_count, ready_count;
    int         wr_cyc [$];
    logic [7:0] msg [64];

    encoder dut (
        .clk(clk), .rst_n(rst_n), .width(width), .enable(enable),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .SRAM_wen(SRAM_wen), .SRAM_addr(SRAM_addr),
        .SRAM_wdata(SRAM_wdata), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM and activity monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (SRAM_wen) begin
            mem[SRAM_addr] = SRAM_wdata;
            wr_count++;
            wr_cyc.push_back(cyc);
        end
        if (done) done_count++;
        if (in_ready) ready_count++;
    end

    task automatic clear_log();
        for (int a = 0; a < 128; a++) mem[a] = 4'hx;
        wr_count = 0;
        done_count = 0;
        ready_count = 0;
        wr_cyc.delete();
    endtask

    // Expected image: column k holds char k, or a space once the message is exhausted
    function automatic int image_errors(input int w, input int n);
        int errs = 0;
        int c, hi, lo;
        for (int k = 0; k < w; k++) begin
            c  = (k < n) ? int'(msg[k]) : 32;
            hi = c / 16;
            lo = c % 16;
            if (mem[k] !== 4'(hi)) errs++;
            if (mem[k + w] !== 4'(lo)) errs++;
            if (mem[k + 2 * w] !== 4'(hi ^ lo)) errs++;
        end
        return errs;
    endfunction

    function automatic int pick_gap(input int fixed_gap, input int max_gap);
        if (fixed_gap >= 0) return fixed_gap;
        return int'($urandom_range(max_gap, 0));
    endfunction

    // Starts an image, feeds msg[0..n-1] (in_last on n-1) with idle gaps while in_ready,
    // and waits for done. lat counts cycles from the enable edge, the first one being 1.
    task automatic run_image(input int w, input int n, input int fixed_gap, input int max_gap,
                             input bit stray_en, output int acc, output int lat,
                             output int first_wen, output bit to);
        int idx, gap, c_en;
        bit stray_done;
        @(posedge clk); #1;
        clear_log();
        @(negedge clk);
        width = 8'(w);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        c_en = cyc;
        idx = 0;
        acc = 0;
        lat = -1;
        to = 1'b1;
        stray_done = 1'b0;
        gap = pick_gap(fixed_gap, max_gap);
        for (int k = 0; k < 1000; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                lat = cyc - c_en + 1;
                to = 1'b0;
                break;
            end
            if (stray_en && !stray_done && SRAM_wen) begin
                enable = 1'b1;
                width = 8'd0;
                stray_done = 1'b1;
            end else begin
                enable = 1'b0;
            end
            if (idx < n && gap > 0) begin
                in_valid = 1'b0;
                if (in_ready) gap--;
            end else if (idx < n) begin
                in_valid = 1'b1;
                in_data = msg[idx];
                in_last = (idx == n - 1);
                if (in_ready) begin
                    idx++;
                    acc++;
                    gap = pick_gap(fixed_gap, max_gap);
                end
            end else begin
                in_valid = 1'b0;
                in_last = 1'b0;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        enable = 1'b0;
        first_wen = (wr_cyc.size() > 0) ? wr_cyc[0] - c_en : -1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        width = 8'd0;
        enable = 1'b0;
        in_valid = 1'b0;
        in_data = 8'd0;
        in_last = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, SRAM_wen, SRAM_addr, SRAM_wdata, done} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {in_ready, SRAM_wen, SRAM_addr, SRAM_wdata, done});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, SRAM_wen, done} !== 3'd0) begin
            failures++;
            $display("FAIL post_reset_idle: got %b expected 000", {in_ready, SRAM_wen, done});
        end
    endtask

    task automatic test_basic_w3();
        int acc, lat, fw, errs;
        bit to;
        msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43;
        run_image(3, 3, 0, 0, 1'b0, acc, lat, fw, to);
        errs = image_errors(3, 3);
        checks++;
        if (to !== 1'b0 || lat !== 13) begin
            failures++;
            $display("FAIL w3_done_latency: got %0d (timeout=%0b) expected 13", lat, to);
        end
        checks++;
        if (fw !== 1) begin
            failures++;
            $display("FAIL w3_first_write_latency: got %0d expected 1", fw);
        end
        checks++;
        if (wr_count !== 9 || errs !== 0) begin
            failures++;
            $display("FAIL w3_image: writes %0d expected 9, bad words %0d expected 0", wr_count, errs);
        end
        checks++;
        if (acc !== 3 || done_count !== 1) begin
            failures++;
            $display("FAIL w3_accept_done: accepted %0d expected 3, done pulses %0d expected 1",
                     acc, done_count);
        end
    endtask

    task automatic test_padding();
        int acc, lat, fw, errs;
        bit to;
        msg[0] = 8'h48;
        run_image(4, 1, 0, 0, 1'b0, acc, lat, fw, to);
        errs = image_errors(4, 1);
        checks++;
        if (to !== 1'b0 || lat !== 17) begin
            failures++;
            $display("FAIL pad_done_latency: got %0d (timeout=%0b) expected 17", lat, to);
        end
        checks++;
        if (wr_count !== 12 || errs !== 0) begin
            failures++;
            $display("FAIL pad_image: writes %0d expected 12, bad words %0d expected 0", wr_count, errs);
        end
        checks++;
        if (acc !== 1 || ready_count !== 1 || done_count !== 1) begin
            failures++;
            $display("FAIL pad_handshake: accepted %0d/1, ready cycles %0d/1, done %0d/1",
                     acc, ready_count, done_count);
        end
    endtask

    task automatic test_backpressure();
        int acc, lat, fw, errs;
        bit to;
        msg[0] = 8'h5A; msg[1] = 8'hC3;
        run_image(2, 2, 5, 0, 1'b0, acc, lat, fw, to);
        errs = image_errors(2, 2);
        checks++;
        if (to !== 1'b0 || lat !== 19) begin
            failures++;
            $display("FAIL bp_done_latency: got %0d (timeout=%0b) expected 19", lat, to);
        end
        checks++;
        if (wr_count !== 6 || errs !== 0) begin
            failures++;
            $display("FAIL bp_image: writes %0d expected 6, bad words %0d expected 0", wr_count, errs);
        end
        checks++;
        if (ready_count !== 12 || acc !== 2) begin
            failures++;
            $display("FAIL bp_ready_cycles: ready %0d expected 12, accepted %0d expected 2",
                     ready_count, acc);
        end
    endtask

    task automatic test_w42();
        int acc, lat, fw, errs;
        bit to;
        for (int i = 0; i < 43; i++) msg[i] = 8'h7E;
        run_image(42, 43, 0, 0, 1'b0, acc, lat, fw, to);
        errs = image_errors(42, 42);
        checks++;
        if (to !== 1'b0 || lat !== 169) begin
            failures++;
            $display("FAIL w42_done_latency: got %0d (timeout=%0b) expected 169", lat, to);
        end
        checks++;
        if ({mem[41], mem[83], mem[125]} !== 12'h7E9) begin
            failures++;
            $display("FAIL w42_last_column: got %h expected 7e9", {mem[41], mem[83], mem[125]});
        end
        checks++;
        if (wr_count !== 126 || errs !== 0 || acc !== 42) begin
            failures++;
            $display("FAIL w42_image: writes %0d/126, bad words %0d/0, accepted %0d/42",
                     wr_count, errs, acc);
        end
    endtask

    task automatic test_w0();
        int acc, lat, fw;
        bit to;
        run_image(0, 0, 0, 0, 1'b0, acc, lat, fw, to);
        checks++;
        if (to !== 1'b0 || lat !== 1 || done_count !== 1) begin
            failures++;
            $display("FAIL w0_done: latency %0d expected 1, pulses %0d expected 1, timeout=%0b",
                     lat, done_count, to);
        end
        checks++;
        if (wr_count !== 0 || ready_count !== 0) begin
            failures++;
            $display("FAIL w0_quiet: writes %0d expected 0, ready cycles %0d expected 0",
                     wr_count, ready_count);
        end
    endtask

    task automatic test_random();
        int acc, lat, fw, errs, w, n, exp_acc;
        bit to;
        for (int it = 0; it < 6; it++) begin
            w = int'($urandom_range(42, 1));
            n = int'($urandom_range(50, 1));
            for (int i = 0; i < n; i++) msg[i] = 8'($urandom_range(126, 32));
            run_image(w, n, -1, 3, 1'b0, acc, lat, fw, to);
            errs = image_errors(w, n);
            exp_acc = (n < w) ? n : w;
            checks++;
            if (to !== 1'b0 || errs !== 0 || wr_count !== 3 * w) begin
                failures++;
                $display("FAIL rand_image[%0d] w=%0d n=%0d: bad words %0d/0, writes %0d/%0d, timeout=%0b",
                         it, w, n, errs, wr_count, 3 * w, to);
            end
            checks++;
            if (acc !== exp_acc || done_count !== 1) begin
                failures++;
                $display("FAIL rand_handshake[%0d]: accepted %0d expected %0d, done %0d expected 1",
                         it, acc, exp_acc, done_count);
            end
        end
    endtask

    task automatic test_reset_mid();
        int idx, acc, lat, fw, errs;
        bit to, hit;
        msg[0] = 8'h31; msg[1] = 8'h9F; msg[2] = 8'hA5; msg[3] = 8'h06;
        @(posedge clk); #1;
        clear_log();
        @(negedge clk);
        width = 8'd4;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        idx = 0;
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (idx < 4) begin
                in_valid = 1'b1;
                in_data = msg[idx];
                in_last = (idx == 3);
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            // Row1 of column 2 lands at address 2+W = 6
            if (SRAM_wen && SRAM_addr == 7'd6) begin
                hit = 1'b1;
                rst_n = 1'b0;
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        #1;
        checks++;
        if (!hit || {in_ready, SRAM_wen, SRAM_addr, SRAM_wdata, done} !== 14'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: reached=%0b outputs %h expected 0", hit,
                     {in_ready, SRAM_wen, SRAM_addr, SRAM_wdata, done});
        end
        repeat (2) @(negedge clk);
        errs = 0;
        for (int k = 0; k < 2; k++) begin
            if (mem[k] !== msg[k][7:4]) errs++;
            if (mem[k + 4] !== msg[k][3:0]) errs++;
            if (mem[k + 8] !== (msg[k][7:4] ^ msg[k][3:0])) errs++;
        end
        if (mem[2] !== msg[2][7:4]) errs++;
        checks++;
        if (wr_count !== 7 || errs !== 0) begin
            failures++;
            $display("FAIL mid_reset_writes: writes %0d expected 7, bad words %0d expected 0",
                     wr_count, errs);
        end
        rst_n = 1'b1;
        clear_log();
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (ready_count !== 0 || wr_count !== 0 || done_count !== 0) begin
            failures++;
            $display("FAIL mid_reset_needs_enable: ready %0d, writes %0d, done %0d, all expected 0",
                     ready_count, wr_count, done_count);
        end
        msg[0] = 8'hD2;
        run_image(1, 1, 0, 0, 1'b1, acc, lat, fw, to);
        errs = image_errors(1, 1);
        checks++;
        if (to !== 1'b0 || lat !== 5 || done_count !== 1) begin
            failures++;
            $display("FAIL restart_w1_done: latency %0d expected 5, pulses %0d expected 1, timeout=%0b",
                     lat, done_count, to);
        end
        checks++;
        if (wr_count !== 3 || errs !== 0 || acc !== 1) begin
            failures++;
            $display("FAIL restart_w1_image: writes %0d/3, bad words %0d/0, accepted %0d/1",
                     wr_count, errs, acc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_w3();
        test_padding();
        test_backpressure();
        test_w42();
        test_w0();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder.md
# encoder

Write-side counterpart of the three-row image decoder. Accepts a stream of ASCII characters over a valid/ready handshake and writes each one into SRAM as one column of a three-row, 4-bit-per-pixel image of programmable width. The resulting image is exactly what the decoder reads back at address k, k+width and k+2*width. The block pulses `done` once all `width` columns are written, padding with spaces if the character stream ends early.

## Interface
- SRAM_DATA_WIDTH, 4, SRAM word width (one nibble per pixel column entry)
- SRAM_ADDR_WIDTH, 7, SRAM address width (128 words)
- DATA_WIDTH, 8, character and width-field width
- clk  input  1  clock; all logic is on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- width  input  DATA_WIDTH  image width in columns; sampled only when `enable` is accepted
- enable  input  1  start pulse; honoured only in IDLE
- in_valid  input  1  character available
- in_data  input  DATA_WIDTH  ASCII character
- in_last  input  1  qualifies `in_data` as the final character of the message
- in_ready  output  1  encoder accepts a character this cycle
- SRAM_wen  output  1  SRAM write strobe
- SRAM_addr  output  SRAM_ADDR_WIDTH  write address
- SRAM_wdata  output  SRAM_DATA_WIDTH  write data
- done  output  1  one-cycle pulse when the image is complete

## Operation
- Column encoding for character c: row0 = c[7:4], row1 = c[3:0], row2 = c[7:4] ^ c[3:0] (check nibble).
- Column k writes go to addresses k, k+W and k+2W, where W is the latched width.
  - Address arithmetic uses the full 8 bits, then truncates to 7.
  - Legal W is 1..42. W > 42 is outside the contract.
- Registers:
  - `w_q`: latched width.
  - `col`: 8-bit column counter.
  - `char_q`: held character.
  - `pad`: sticky flag meaning the message has ended.
- States: IDLE, FETCH, W0, W1, W2, DONE.
- IDLE: `enable`=1 latches W and clears `col` and `pad`. Next state is DONE if W==0, otherwise FETCH.
- FETCH:
  - If `pad`=0: `in_ready`=1. On `in_valid`, latch `in_data` into `char_q`, set `pad` from `in_last`, and go to W0. Otherwise stay.
  - If `pad`=1: `in_ready`=0, load `char_q`=0x20, and go to W0 without a handshake.
- W0/W1/W2: write row0/row1/row2 of `char_q` at col / col+W / col+2W.
- End of W2: `col` increments. If the new `col`==W, go to DONE; otherwise go to FETCH.
- DONE: `done`=1 for one cycle, then IDLE.
- Boundary and corner cases:
  - `enable` outside IDLE is ignored.
  - Characters offered after column W-1 has been fetched are not consumed; `in_ready` stays 0.
  - `in_last` on the character for column W-1 is a normal finish with no padding.
  - `in_last` together with W==1: one column is written, then DONE.
  - `in_valid` and `enable` in the same IDLE cycle: the character is not accepted until FETCH.

## Timing
- All outputs are registered or decoded from state/registers only. No combinational path from inputs to outputs, except `in_ready`, which depends only on state and `pad`.
- Reset values: `in_ready`=0, `SRAM_wen`=0, `SRAM_addr`=0, `SRAM_wdata`=0, `done`=0. State returns to IDLE and `col`/`pad`/`w_q`/`char_q` are cleared.
- Reset mid-operation aborts immediately with no further writes. Words already written stay in SRAM.
- Latency:
  - `enable` accepted at edge t → `in_ready`=1 during cycle t+1.
  - Handshake at edge h → `SRAM_wen`=1 with the row0 write during cycle h+1; row1 at h+2; row2 at h+3.
- Throughput: 4 cycles per column with no backpressure (FETCH + 3 writes). Padded columns also take 4 cycles.
- `SRAM_wen` is high only in W0..W2. `SRAM_addr` and `SRAM_wdata` hold their last value otherwise.
- `done` is asserted in the cycle after the final W2. Total time for a complete image without stalls is 4W+1 cycles after `enable`.

## Test plan
- W=3, chars 0x41, 0x42, 0x43 (last on 0x43), `in_valid` always 1:
  - Writes: addr0=4, addr3=1, addr6=5; addr1=4, addr4=2, addr7=6; addr2=4, addr5=3, addr8=7.
  - `done` pulses 13 cycles after `enable`.
- W=4, single char 0x48 with `in_last`=1:
  - Column 0 writes 4/8/0xC at addresses 0/4/8.
  - Columns 1..3 write 2/0/2 (space padding) with `in_ready` held 0.
  - One `done` pulse.
- Backpressure: W=2, `in_valid` low for 5 cycles before each char.
  - FETCH holds, no `SRAM_wen` during the stall, writes are correct afterwards, `in_ready` drops on acceptance.
- W=42, 42 chars 0x7E:
  - The last column writes 7/0xE/9 at addresses 41/83/125.
  - A 43rd offered char is never accepted.
- W=0: `enable` → `done` the following cycle, zero writes, `in_ready` never 1.
- Reset mid-operation: `rst_n` low during W1 of column 2.
  - All outputs are 0 immediately.
  - After release, `enable` is needed to restart, and a fresh W=1 run completes correctly.
  - A stray `enable` pulse during W0 of that run is ignored.
